// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package fifo_arb_pkg;

   // Flush sequencing states
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CLR   = 2'd2
   } arb_state_e;

   // Width of the consecutive-grant counter (BURST is at most 15)
   localparam int CNT_W = 4;

   // Index width for n requesters, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester-side and FIFO-side signals of the write arbiter.
// Latency: none (wiring only).
// Backpressure: ack toward requesters; fifo_full/fifo_full_n from the FIFO.
//   master: arbiter side (drives ack, fifo_we/fifo_din/fifo_clr, grant_id, busy)
//   slave : environment side (drives req, wdata, flush_req, FIFO flags)
interface fifo_wr_arb_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 8
);
   import fifo_arb_pkg::*;

   localparam int IW = idx_w(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*DW-1:0] wdata;
   logic [N_REQ-1:0]    ack;
   logic                flush_req;
   logic                fifo_we;
   logic [DW-1:0]       fifo_din;
   logic                fifo_clr;
   logic                fifo_full;
   logic                fifo_full_n;
   logic [IW-1:0]       grant_id;
   logic                busy;

   modport master (
      input  req, wdata, flush_req, fifo_full, fifo_full_n,
      output ack, fifo_we, fifo_din, fifo_clr, grant_id, busy
   );

   modport slave (
      output req, wdata, flush_req, fifo_full, fifo_full_n,
      input  ack, fifo_we, fifo_din, fifo_clr, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: keeps the current owner while it may hold, else next requester after it.
// Latency: combinational.
// Backpressure: none; pick_vld only says some requester is present.
//   req      in   per-requester valid
//   owner    in   index of the last granted requester
//   hold     in   owner is still within its burst allowance
//   pick     out  chosen index (owner when nothing is picked)
//   pick_vld out  a requester was chosen
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    owner,
   input  logic             hold,
   output logic [IW-1:0]    pick,
   output logic             pick_vld
);

   always_comb begin
      int            idx;
      logic [IW-1:0] idx_l;
      pick     = owner;
      pick_vld = 1'b0;
      idx      = 0;
      idx_l    = '0;
      if (hold && req[owner]) begin
         pick_vld = 1'b1;
      end else begin
         // Cyclic search from owner+1; k==N_REQ wraps back to owner itself,
         // so a lone requester keeps winning past its burst limit.
         for (int k = 1; k <= N_REQ; k++) begin
            idx   = (int'(owner) + k) % N_REQ;
            idx_l = IW'(idx);
            if (!pick_vld && req[idx_l]) begin
               pick     = idx_l;
               pick_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters, with burst limit and flush sequencing.
// Latency: ack in cycle t -> fifo_we/fifo_din in cycle t+1; flush: DRAIN at t+1, fifo_clr at t+2, RUN at t+3.
// Backpressure: ack withheld on fifo_full, on almost-full with a write in flight, during flush and reset.
//   clk, rst      clock and asynchronous active-high reset
//   bus (master)  req/wdata/ack requester handshake, flush_req, FIFO write port and flags, grant_id, busy
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input logic            clk,
   input logic            rst,
   fifo_wr_arb_if.master  bus
);

   localparam int IW = idx_w(N_REQ);

   arb_state_e       state_q, state_d;
   logic [IW-1:0]    owner_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fifo_we_q;
   logic [DW-1:0]    fifo_din_q;
   logic             fifo_clr_q;

   logic             hold;
   logic             can_wr;
   logic             xfer;
   logic [IW-1:0]    pick;
   logic             pick_vld;
   logic [N_REQ-1:0] ack;

   // cnt==0 only after reset or clear: no burst is running, so the owner
   // register merely marks where the cyclic search starts (index 0 first).
   assign hold = (cnt_q != '0) && (cnt_q < CNT_W'(BURST));

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req      (bus.req),
      .owner    (owner_q),
      .hold     (hold),
      .pick     (pick),
      .pick_vld (pick_vld)
   );

   // A write already in flight with only one free entry would take the last
   // slot, so the next cycle must not issue another one.
   assign can_wr = (state_q == RUN) && !bus.flush_req && !bus.fifo_full &&
                   !(fifo_we_q && bus.fifo_full_n);

   always_comb begin
      ack = '0;
      if (pick_vld && can_wr && !rst) begin
         ack[pick] = 1'b1;
      end
   end

   assign xfer = |ack;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.flush_req) state_d = DRAIN;
         DRAIN:   state_d = CLR;
         CLR:     state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q    <= IW'(N_REQ - 1);
         cnt_q      <= '0;
         fifo_we_q  <= 1'b0;
         fifo_din_q <= '0;
         fifo_clr_q <= 1'b0;
      end else begin
         fifo_we_q  <= xfer;
         fifo_clr_q <= (state_d == CLR);
         if (state_q == CLR) begin
            owner_q <= IW'(N_REQ - 1);
            cnt_q   <= '0;
         end else if (xfer) begin
            fifo_din_q <= bus.wdata[int'(pick)*DW +: DW];
            if (pick == owner_q) begin
               // Saturates: a lone requester keeps winning past BURST.
               if (cnt_q < CNT_W'(BURST)) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               owner_q <= pick;
               cnt_q   <= CNT_W'(1);
            end
         end
      end
   end

   assign bus.ack      = ack;
   assign bus.fifo_we  = fifo_we_q;
   assign bus.fifo_din = fifo_din_q;
   assign bus.fifo_clr = fifo_clr_q;
   assign bus.grant_id = owner_q;
   assign bus.busy     = (state_q != RUN);

endmodule
